mac_seq_ctrl: RTL and testbench

- Initiator-side sequencer for mac_top. It accepts a stream of signed operand pairs with a last-of-vector flag and buffers them in a small FIFO.
- For each pair it drives the start/ready_mac handshake of the MAC. It pulses clr_acc at the start of each vector.
- On the final pair it captures the MAC's 40-bit Accumulator into a result register, which is offered downstream on a valid/ready handshake.
- It sits between the operand source (DMA/register bank) and mac_top, replacing bench-driven stimulus.

---
 rtl/mac_seq_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_mac_seq_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: initiator-side sequencer for mac_top.
//
// Buffers signed operand pairs {last, a, b} in a small FIFO and issues them
// to the MAC one at a time over the start/ready_mac handshake. The MAC
// accumulator is cleared before the first pair of each vector. When the last
// pair completes, the accumulator is captured and offered downstream on a
// valid/ready handshake. A MAC that stays silent for TIMEOUT WAIT cycles
// parks the sequencer in a sticky error state until reset.
//
// Ports:
//   clk, rst_n                 clock; synchronous active-low reset
//   in_valid_i/in_ready_o      operand pair handshake
//   in_a_i, in_b_i, in_last_i  operands (two's complement) and end-of-vector flag
//   mac_start_o, mac_clr_acc_o one-cycle pulses to the MAC
//   mac_a_o, mac_b_o           registered operands, stable from ISSUE to next ISSUE
//   mac_ready_i, mac_acc_i     MAC completion level and accumulator value
//   res_valid_o/res_ready_i    result handshake
//   res_data_o, res_count_o    captured accumulator and products in the vector
//   err_timeout_o              sticky MAC timeout flag
//   busy_o                     FSM not idle or FIFO not empty
module mac_seq_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_a_i,
    input  logic [DATA_WIDTH-1:0] in_b_i,
    input  logic                  in_last_i,
    output logic                  mac_start_o,
    output logic                  mac_clr_acc_o,
    output logic [DATA_WIDTH-1:0] mac_a_o,
    output logic [DATA_WIDTH-1:0] mac_b_o,
    input  logic                  mac_ready_i,
    input  logic [ACC_WIDTH-1:0]  mac_acc_i,
    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic [ACC_WIDTH-1:0]  res_data_o,
    output logic [CNT_WIDTH-1:0]  res_count_o,
    output logic                  err_timeout_o,
    output logic                  busy_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_ISSUE, S_GUARD, S_WAIT, S_DONE, S_ERR
    } state_e;

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = 2 * DATA_WIDTH + 1;
    localparam int TMO_W   = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    // ---------------- operand FIFO ----------------
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic               fifo_empty, fifo_full, push, pop;
    logic [ENTRY_W-1:0] head;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    // A pop in the same cycle does not free a slot for a push while full.
    assign in_ready_o = rst_n && !fifo_full;
    assign push       = in_valid_i && in_ready_o;
    assign head       = fifo_mem[rd_ptr_q[PTR_W-1:0]];

    // NOTE: the storage array has no reset; the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[PTR_W-1:0]] <= {in_last_i, in_a_i, in_b_i};
        end
    end

    // ---------------- FSM ----------------
    state_e state_q, state_d;
    logic   first_q, first_d;
    logic   cur_last_q, cur_last_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    // NOTE: every register assignment in always_ff is non-blocking so all state updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: each always_comb assigns defaults first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!fifo_empty) state_d = first_q ? S_CLR : S_ISSUE;
            S_CLR:   state_d = S_ISSUE;
            S_ISSUE: state_d = S_GUARD;
            S_GUARD: state_d = S_WAIT;
            S_WAIT: begin
                // Completion wins over a timeout landing in the same cycle.
                if (mac_ready_i)            state_d = cur_last_q ? S_DONE : S_IDLE;
                else if (tmo_q == TMO_LAST) state_d = S_ERR;
            end
            S_DONE:  if (res_ready_i) state_d = S_IDLE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mac_start_o   = 1'b0;
        mac_clr_acc_o = 1'b0;
        pop           = 1'b0;
        case (state_q)
            S_CLR:   mac_clr_acc_o = 1'b1;
            S_ISSUE: begin
                mac_start_o = 1'b1;
                pop         = 1'b1;
            end
            default: ;
        endcase
        busy_o = (state_q != S_IDLE) || !fifo_empty;
    end

    // ---------------- datapath ----------------
    logic [DATA_WIDTH-1:0] mac_a_q, mac_a_d, mac_b_q, mac_b_d;
    logic                  res_valid_q, res_valid_d;
    logic [ACC_WIDTH-1:0]  res_data_q, res_data_d;
    logic [CNT_WIDTH-1:0]  res_count_q, res_count_d;
    logic                  err_q, err_d;

    always_comb begin
        wr_ptr_d    = wr_ptr_q + {{PTR_W{1'b0}}, push};
        rd_ptr_d    = rd_ptr_q + {{PTR_W{1'b0}}, pop};
        first_d     = first_q;
        cur_last_d  = cur_last_q;
        tmo_d       = tmo_q;
        mac_a_d     = mac_a_q;
        mac_b_d     = mac_b_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_count_d = res_count_q;
        err_d       = err_q;

        // Operands are loaded on entry to ISSUE so they are already on
        // mac_a/mac_b while mac_start is high. The head is stable until the
        // ISSUE pop, so reading it one cycle early is safe.
        if (state_d == S_ISSUE) begin
            cur_last_d = head[ENTRY_W-1];
            mac_a_d    = head[ENTRY_W-2 -: DATA_WIDTH];
            mac_b_d    = head[DATA_WIDTH-1:0];
        end

        case (state_q)
            S_CLR: begin
                res_count_d = '0;
                first_d     = 1'b0;
            end
            S_GUARD: tmo_d = '0;
            S_WAIT: begin
                if (mac_ready_i) begin
                    if (res_count_q != '1) res_count_d = res_count_q + CNT_WIDTH'(1);
                    if (cur_last_q) begin
                        res_data_d  = mac_acc_i;
                        res_valid_d = 1'b1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_DONE: begin
                if (res_ready_i) begin
                    res_valid_d = 1'b0;
                    first_d     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            first_q     <= 1'b1;
            cur_last_q  <= 1'b0;
            tmo_q       <= '0;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_count_q <= '0;
            err_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            first_q     <= first_d;
            cur_last_q  <= cur_last_d;
            tmo_q       <= tmo_d;
            mac_a_q     <= mac_a_d;
            mac_b_q     <= mac_b_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_count_q <= res_count_d;
            err_q       <= err_d;
        end
    end

    assign mac_a_o       = mac_a_q;
    assign mac_b_o       = mac_b_q;
    assign res_valid_o   = res_valid_q;
    assign res_data_o    = res_data_q;
    assign res_count_o   = res_count_q;
    assign err_timeout_o = err_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl. A behavioural MAC answers mac_start after
// a programmable latency (or with ready tied high); a second instance with
// TIMEOUT=8 and a silent MAC covers the error path.
module tb_mac_seq_ctrl;

    localparam int DW = 16;
    localparam int AW = 40;
    localparam int CW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          in_valid, in_ready, in_last;
    logic [DW-1:0] in_a, in_b;
    logic          mac_start, mac_clr_acc, mac_ready;
    logic [DW-1:0] mac_a, mac_b;
    logic [AW-1:0] mac_acc;
    logic          res_valid, res_ready, err_timeout, busy;
    logic [AW-1:0] res_data;
    logic [CW-1:0] res_count;

    logic          t_in_valid, t_in_ready, t_in_last;
    logic [DW-1:0] t_in_a, t_in_b;
    logic          t_mac_start, t_mac_clr_acc, t_mac_ready;
    logic [DW-1:0] t_mac_a, t_mac_b;
    logic [AW-1:0] t_mac_acc;
    logic          t_res_valid, t_res_ready, t_err_timeout, t_busy;
    logic [AW-1:0] t_res_data;
    logic [CW-1:0] t_res_count;

    mac_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_a_i(in_a), .in_b_i(in_b),
        .in_last_i(in_last), .mac_start_o(mac_start), .mac_clr_acc_o(mac_clr_acc),
        .mac_a_o(mac_a), .mac_b_o(mac_b), .mac_ready_i(mac_ready), .mac_acc_i(mac_acc),
        .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data),
        .res_count_o(res_count), .err_timeout_o(err_timeout), .busy_o(busy)
    );

    mac_seq_ctrl #(.TIMEOUT(8)) dut_t (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(t_in_valid), .in_ready_o(t_in_ready), .in_a_i(t_in_a), .in_b_i(t_in_b),
        .in_last_i(t_in_last), .mac_start_o(t_mac_start), .mac_clr_acc_o(t_mac_clr_acc),
        .mac_a_o(t_mac_a), .mac_b_o(t_mac_b), .mac_ready_i(t_mac_ready), .mac_acc_i(t_mac_acc),
        .res_valid_o(t_res_valid), .res_ready_i(t_res_ready), .res_data_o(t_res_data),
        .res_count_o(t_res_count), .err_timeout_o(t_err_timeout), .busy_o(t_busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural MAC ----------------
    // ready stays high after a result and only drops one edge after the
    // start edge, so a sequencer that looks at ready during GUARD would see
    // the stale level.
    int                 lat  = 17;
    bit                 tied = 1'b0;
    logic               m_rdy;
    int                 m_cnt;
    logic signed [AW-1:0] m_acc, m_prod, prod_now;
    logic signed [DW-1:0] sa, sb;

    assign sa        = mac_a;
    assign sb        = mac_b;
    assign prod_now  = AW'(sa) * AW'(sb);
    assign mac_acc   = m_acc;
    assign mac_ready = tied ? 1'b1 : m_rdy;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_acc  <= '0;
            m_prod <= '0;
            m_rdy  <= 1'b1;
            m_cnt  <= 0;
        end else begin
            if (mac_clr_acc) m_acc <= '0;
            if (mac_start) begin
                if (tied) m_acc <= m_acc + prod_now;
                else begin
                    m_cnt  <= lat;
                    m_prod <= prod_now;
                end
            end else if (m_cnt != 0) begin
                if (m_cnt == lat) m_rdy <= 1'b0;
                if (m_cnt == 1) begin
                    m_rdy <= 1'b1;
                    m_acc <= m_acc + m_prod;
                end
                m_cnt <= m_cnt - 1;
            end
        end
    end

    // ---------------- monitor (1 ns after each rising edge) ----------------
    int          cyc = 0, start_cnt = 0, clr_cnt = 0, t_start_cnt = 0, t_clr_cnt = 0;
    logic [31:0] exp_q[$];
    int          start_cyc_q[$];
    logic [31:0] mon_exp;

    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (mac_clr_acc) clr_cnt++;
        if (mac_start) begin
            check("pair_pending_at_start", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                check("issued_operands", 64'({mac_a, mac_b}), 64'(mon_exp));
            end
            start_cnt++;
            start_cyc_q.push_back(cyc);
        end
        if (t_mac_clr_acc) t_clr_cnt++;
        if (t_mac_start) t_start_cnt++;
    end

    // ---------------- stimulus helpers ----------------
    int accepted = 0, accepted_at_stall = 0;
    bit stall_seen = 1'b0;

    task automatic send(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b,
                        input logic last, input string tag);
        int n = 0;
        in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
        while (!in_ready && n < 300) begin
            if (!stall_seen) begin
                stall_seen        = 1'b1;
                accepted_at_stall = accepted;
            end
            @(negedge clk);
            n++;
        end
        check({"accept_", tag}, 64'(in_ready), 64'd1);
        exp_q.push_back({a, b});
        accepted++;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic t_send(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b,
                          input logic last);
        int n = 0;
        t_in_valid = 1'b1; t_in_a = a; t_in_b = b; t_in_last = last;
        while (!t_in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("t_accept", 64'(t_in_ready), 64'd1);
        @(negedge clk);
        t_in_valid = 1'b0;
    endtask

    task automatic wait_res(input int budget, input string tag);
        int n = 0;
        while (res_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({"res_valid_", tag}, 64'(res_valid), 64'd1);
    endtask

    task automatic handshake(input string tag);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check({"res_valid_cleared_", tag}, 64'(res_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    int          c0, s0;
    longint      sum;
    logic [39:0] stream_exp;

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; res_ready = 1'b0;
        t_in_valid = 1'b0; t_in_a = '0; t_in_b = '0; t_in_last = 1'b0; t_res_ready = 1'b0;
        t_mac_ready = 1'b0; t_mac_acc = '0;

        // ---- reset state ----
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_mac_start", 64'(mac_start), 64'd0);
        check("rst_mac_clr_acc", 64'(mac_clr_acc), 64'd0);
        check("rst_mac_ab", 64'({mac_a, mac_b}), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_res_data", 64'(res_data), 64'd0);
        check("rst_res_count", 64'(res_count), 64'd0);
        check("rst_err", 64'(err_timeout), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // ---- vector (10,5),(2,-3),(100,10 last), MAC latency 17 ----
        lat = 17;
        send(16'sd10, 16'sd5, 1'b0, "v1p0");                 // mid cycle 1
        check("c1_no_clr", 64'(mac_clr_acc), 64'd0);
        check("c1_no_start", 64'(mac_start), 64'd0);
        @(negedge clk);                                      // cycle 2
        check("c2_clr", 64'(mac_clr_acc), 64'd1);
        check("c2_no_start", 64'(mac_start), 64'd0);
        @(negedge clk);                                      // cycle 3
        check("c3_start", 64'(mac_start), 64'd1);
        check("c3_no_clr", 64'(mac_clr_acc), 64'd0);
        check("c3_mac_a", 64'(mac_a), 64'd10);
        check("c3_mac_b", 64'(mac_b), 64'd5);
        @(negedge clk);                                      // cycle 4, GUARD
        check("c4_start_single", 64'(mac_start), 64'd0);
        send(-16'sd3 + 16'sd5, -16'sd3, 1'b0, "v1p1");
        send(16'sd100, 16'sd10, 1'b1, "v1p2");
        wait_res(400, "v1");
        check("v1_res_data", 64'(res_data), 64'd1044);
        check("v1_res_count", 64'(res_count), 64'd3);
        check("v1_clr_cnt", 64'(clr_cnt), 64'd1);
        check("v1_start_cnt", 64'(start_cnt), 64'd3);
        check("v1_mac_a_hold", 64'(mac_a), 64'd100);
        handshake("v1");
        check("v1_idle_busy", 64'(busy), 64'd0);

        // ---- [(3,4) last] then [(-7,6) last] with a 5-cycle stall ----
        lat = 5;
        c0 = clr_cnt; s0 = start_cnt;
        send(16'sd3, 16'sd4, 1'b1, "v2");
        wait_res(100, "v2");
        check("v2_res_data", 64'(res_data), 64'd12);
        check("v2_res_count", 64'(res_count), 64'd1);
        send(-16'sd7, 16'sd6, 1'b1, "v3");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_res_valid", 64'(res_valid), 64'd1);
            check("stall_res_data", 64'(res_data), 64'd12);
        end
        check("stall_no_start", 64'(start_cnt - s0), 64'd1);
        check("stall_no_clr", 64'(clr_cnt - c0), 64'd1);
        check("stall_busy", 64'(busy), 64'd1);
        handshake("v2");
        wait_res(100, "v3");
        check("v3_res_data", 64'(res_data), 64'h00_00FF_FFFF_FFD6);
        check("v3_res_count", 64'(res_count), 64'd1);
        check("v3_second_clr", 64'(clr_cnt - c0), 64'd2);
        check("v3_start_cnt", 64'(start_cnt - s0), 64'd2);
        handshake("v3");

        // ---- 10-pair stream, MAC latency 20 ----
        lat = 20;
        s0 = start_cnt; accepted = 0; stall_seen = 1'b0; sum = 0;
        for (int i = 0; i < 10; i++) begin
            send(16'(300 * i - 1200), 16'(7 - 3 * i), i == 9, "stream");
            sum += longint'(300 * i - 1200) * longint'(7 - 3 * i);
        end
        check("stream_stall_seen", 64'(stall_seen), 64'd1);
        check("stream_full_at_5_accepted", 64'(accepted_at_stall), 64'd5);
        wait_res(600, "stream");
        stream_exp = sum[39:0];
        check("stream_ref_sum", 64'(stream_exp), 64'h00_FF_FFFE_B7E0);
        check("stream_res_data", 64'(res_data), 64'(stream_exp));
        check("stream_res_count", 64'(res_count), 64'd10);
        check("stream_start_cnt", 64'(start_cnt - s0), 64'd10);
        handshake("stream");

        // ---- mac_ready tied high: 4-cycle issue spacing ----
        tied = 1'b1;
        s0 = start_cnt;
        start_cyc_q.delete();
        for (int i = 0; i < 4; i++) send(16'(i + 1), 16'(i + 1), i == 3, "tied");
        wait_res(100, "tied");
        check("tied_res_data", 64'(res_data), 64'd30);
        check("tied_res_count", 64'(res_count), 64'd4);
        check("tied_start_cnt", 64'(start_cnt - s0), 64'd4);
        check("tied_start_log", 64'(start_cyc_q.size()), 64'd4);
        for (int k = 1; k < start_cyc_q.size(); k++)
            check("tied_spacing", 64'(start_cyc_q[k] - start_cyc_q[k-1]), 64'd4);
        handshake("tied");

        // non-first pair issued from idle with an empty FIFO
        send(16'sd5, 16'sd5, 1'b0, "nf0");
        repeat (6) @(negedge clk);
        check("nf_idle", 64'(busy), 64'd0);
        send(16'sd6, 16'sd6, 1'b1, "nf1");                   // mid cycle 1
        check("nf_c1_no_start", 64'(mac_start), 64'd0);
        @(negedge clk);                                      // cycle 2
        check("nf_c2_start", 64'(mac_start), 64'd1);
        check("nf_c2_no_clr", 64'(mac_clr_acc), 64'd0);
        check("nf_c2_mac_a", 64'(mac_a), 64'd6);
        wait_res(100, "nf");
        check("nf_res_data", 64'(res_data), 64'd61);
        check("nf_res_count", 64'(res_count), 64'd2);
        handshake("nf");

        // ---- reset for one edge during WAIT ----
        tied = 1'b0; lat = 17;
        send(16'sd9, 16'sd9, 1'b1, "pre_rst");
        repeat (5) @(negedge clk);                           // cycle 6, WAIT
        check("pre_rst_mac_a", 64'(mac_a), 64'd9);
        check("pre_rst_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("wrst_in_ready", 64'(in_ready), 64'd0);
        check("wrst_pulses", 64'({mac_start, mac_clr_acc}), 64'd0);
        check("wrst_mac_ab", 64'({mac_a, mac_b}), 64'd0);
        check("wrst_res_valid", 64'(res_valid), 64'd0);
        check("wrst_res_data", 64'(res_data), 64'd0);
        check("wrst_res_count", 64'(res_count), 64'd0);
        check("wrst_err", 64'(err_timeout), 64'd0);
        check("wrst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        c0 = clr_cnt;
        send(16'sd6, 16'sd7, 1'b1, "post_rst");
        @(negedge clk);                                      // cycle 2
        check("post_rst_clr", 64'(mac_clr_acc), 64'd1);
        wait_res(100, "post_rst");
        check("post_rst_res_data", 64'(res_data), 64'd42);
        check("post_rst_res_count", 64'(res_count), 64'd1);
        check("post_rst_clr_cnt", 64'(clr_cnt - c0), 64'd1);
        handshake("post_rst");

        // ---- TIMEOUT=8 instance, MAC never ready ----
        t_send(16'sd1, 16'sd1, 1'b1);                        // mid cycle 1
        @(negedge clk);                                      // cycle 2
        check("t_clr", 64'(t_mac_clr_acc), 64'd1);
        @(negedge clk);                                      // cycle 3
        check("t_start", 64'(t_mac_start), 64'd1);
        repeat (9) @(negedge clk);                           // cycle 12, last WAIT
        check("t_err_not_yet", 64'(t_err_timeout), 64'd0);
        @(negedge clk);                                      // cycle 13
        check("t_err_set", 64'(t_err_timeout), 64'd1);
        for (int i = 0; i < 4; i++) t_send(16'(i), 16'(i), 1'b0);
        check("t_fifo_full", 64'(t_in_ready), 64'd0);
        repeat (5) @(negedge clk);
        check("t_err_sticky", 64'(t_err_timeout), 64'd1);
        check("t_busy", 64'(t_busy), 64'd1);
        check("t_start_cnt", 64'(t_start_cnt), 64'd1);
        check("t_clr_cnt", 64'(t_clr_cnt), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
